// File: rtl/emu_seq_pkg.sv
// Shared constants for the fir_pe co-emulation stream sequencer: default frame
// geometry, clk_dut phase lengths and the FSM state encoding.
package emu_seq_pkg;

  localparam int N_IN_DEF       = 4;
  localparam int N_OUT_DEF      = 3;
  localparam int DUT_CLK_HI_DEF = 2;
  localparam int DUT_CLK_LO_DEF = 2;

  typedef logic [3:0] state_t;

  localparam logic [3:0] ST_RECV   = 4'd0;
  localparam logic [3:0] ST_LOAD   = 4'd1;
  localparam logic [3:0] ST_SETTLE = 4'd2;
  localparam logic [3:0] ST_CLK_HI = 4'd3;
  localparam logic [3:0] ST_CLK_LO = 4'd4;
  localparam logic [3:0] ST_GET    = 4'd5;
  localparam logic [3:0] ST_RADDR  = 4'd6;
  localparam logic [3:0] ST_RWAIT  = 4'd7;
  localparam logic [3:0] ST_RCAP   = 4'd8;
  localparam logic [3:0] ST_SEND   = 4'd9;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/emu_stream_seq_if.sv
// Host byte streams plus the parallel-IO bus of the fir_pe emulation wrapper.
// master = sequencer side, slave = host/wrapper side.
interface emu_stream_seq_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] emu_addr;
  logic [7:0] emu_wdata;
  logic [7:0] emu_rdata;
  logic       load_emu;
  logic       get_emu;
  logic       clk_dut;

  modport master (
    input  rx_data, rx_valid, tx_ready, emu_rdata,
    output rx_ready, tx_data, tx_valid, emu_addr, emu_wdata, load_emu, get_emu, clk_dut
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, emu_rdata,
    input  rx_ready, tx_data, tx_valid, emu_addr, emu_wdata, load_emu, get_emu, clk_dut
  );
endinterface

// File: rtl/emu_clkgen.sv
// clk_dut phase generator: registered clock follows the CLK_HI phase, with
// combinational done pulses on the last cycle of each phase.
module emu_clkgen #(
  parameter int HI = 2,
  parameter int LO = 2
) (
  input  logic clk_emu,
  input  logic rst_n,
  input  logic in_hi,
  input  logic in_lo,
  output logic clk_dut,
  output logic hi_done,
  output logic lo_done
);

  localparam int MAXP = (HI > LO) ? HI : LO;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  logic [CW-1:0] cnt;

  assign hi_done = in_hi && (cnt == CW'(HI - 1));
  assign lo_done = in_lo && (cnt == CW'(LO - 1));

  // clk_dut lags the phase request by one cycle, so it comes straight off a flop.
  always_ff @(posedge clk_emu or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_dut <= 1'b0;
    end else begin
      clk_dut <= in_hi;
      if (hi_done || lo_done)  cnt <= '0;
      else if (in_hi || in_lo) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/emu_stream_seq.sv
// Host-side frame sequencer for the fir_pe co-emulation wrapper: writes N_IN
// stimulus bytes, strobes load / one clk_dut cycle / get, streams N_OUT results.
module emu_stream_seq
  import emu_seq_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int N_OUT      = N_OUT_DEF,
  parameter int DUT_CLK_HI = DUT_CLK_HI_DEF,
  parameter int DUT_CLK_LO = DUT_CLK_LO_DEF
) (
  input  logic                clk_emu,
  input  logic                rst_n,
  emu_stream_seq_if.master    bus,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  localparam int IW = idx_w(N_IN);
  localparam int OW = idx_w(N_OUT);
  localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT - 1);

  state_t        state;
  logic [IW-1:0] in_idx;
  logic [OW-1:0] out_idx;
  logic          rx_ready_q, tx_valid_q, load_q, get_q;
  logic [7:0]    tx_data_q, emu_addr_q, emu_wdata_q;
  logic          in_hi, in_lo, hi_done, lo_done, clk_dut;
  logic          rx_fire;

  assign in_hi   = (state == ST_CLK_HI);
  assign in_lo   = (state == ST_CLK_LO);
  assign rx_fire = bus.rx_valid && rx_ready_q;

  emu_clkgen #(.HI(DUT_CLK_HI), .LO(DUT_CLK_LO)) u_clkgen (
    .clk_emu (clk_emu),
    .rst_n   (rst_n),
    .in_hi   (in_hi),
    .in_lo   (in_lo),
    .clk_dut (clk_dut),
    .hi_done (hi_done),
    .lo_done (lo_done)
  );

  assign bus.rx_ready  = rx_ready_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.emu_addr  = emu_addr_q;
  assign bus.emu_wdata = emu_wdata_q;
  assign bus.load_emu  = load_q;
  assign bus.get_emu   = get_q;
  assign bus.clk_dut   = clk_dut;

  // Every output is a flop driven in the state that owns it, so each strobe
  // appears one cycle after its state is entered.
  always_ff @(posedge clk_emu or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RECV;
      in_idx      <= '0;
      out_idx     <= '0;
      rx_ready_q  <= 1'b1;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      emu_addr_q  <= '0;
      emu_wdata_q <= '0;
      load_q      <= 1'b0;
      get_q       <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      load_q <= 1'b0;
      get_q  <= 1'b0;
      case (state)
        ST_RECV: if (rx_fire) begin
          emu_addr_q  <= 8'(in_idx);
          emu_wdata_q <= bus.rx_data;
          if (in_idx == IN_LAST) begin
            in_idx     <= '0;
            rx_ready_q <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_LOAD;
          end else begin
            in_idx <= in_idx + IW'(1);
          end
        end
        // Wrapper commits the last stimulus byte on this edge; load follows it.
        ST_LOAD: begin
          load_q <= 1'b1;
          state  <= ST_SETTLE;
        end
        ST_SETTLE: state <= ST_CLK_HI;
        ST_CLK_HI: if (hi_done) state <= ST_CLK_LO;
        ST_CLK_LO: if (lo_done) state <= ST_GET;
        ST_GET: begin
          get_q <= 1'b1;
          state <= ST_RADDR;
        end
        ST_RADDR: begin
          emu_addr_q <= 8'(out_idx);
          state      <= ST_RWAIT;
        end
        ST_RWAIT: state <= ST_RCAP;
        ST_RCAP: begin
          tx_data_q  <= bus.emu_rdata;
          tx_valid_q <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: if (bus.tx_ready) begin
          tx_valid_q <= 1'b0;
          if (out_idx == OUT_LAST) begin
            out_idx    <= '0;
            frame_cnt  <= frame_cnt + 16'd1;
            rx_ready_q <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_RECV;
          end else begin
            out_idx <= out_idx + OW'(1);
            state   <= ST_RADDR;
          end
        end
        default: begin
          state      <= ST_RECV;
          rx_ready_q <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
